// File: rtl/usb_ulpi_pkg.sv
// Shared ULPI definitions for the host chirp controller: state codes,
// register addresses, FUN_CTRL/OTG_CTRL values and linestate encodings.
package usb_ulpi_pkg;

  typedef enum logic [7:0] {
    ST_IDLE         = 8'h00,
    ST_WR_OTG       = 8'h01,
    ST_WAIT_WR      = 8'h02,
    ST_WR_FUN_RST   = 8'h03,
    ST_DET_K        = 8'h04,
    ST_WAIT_K_END   = 8'h05,
    ST_TX_OPEN      = 8'h06,
    ST_CHIRP_K      = 8'h07,
    ST_CHIRP_J      = 8'h08,
    ST_TX_CLOSE     = 8'h09,
    ST_WR_FUN_HS    = 8'h0A,
    ST_WAIT_RST_END = 8'h0B,
    ST_DONE_HS      = 8'h0C,
    ST_WR_FUN_FS    = 8'h0D,
    ST_DONE_FS      = 8'h0E,
    ST_FAIL         = 8'h0F
  } chirp_state_e;

  localparam logic [5:0] ULPI_FUN_CTRL = 6'h04;
  localparam logic [5:0] ULPI_OTG_CTRL = 6'h0A;

  localparam logic [7:0] OTG_PULLDOWNS = 8'h06;
  localparam logic [7:0] FUN_CHIRP     = 8'h50;
  localparam logic [7:0] FUN_HS        = 8'h40;
  localparam logic [7:0] FUN_FS        = 8'h45;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;

  localparam logic [7:0] TX_K_BYTE = 8'h00;
  localparam logic [7:0] TX_J_BYTE = 8'hFF;

  // Where a completed register write leads; each WR_x has one successor.
  function automatic chirp_state_e wr_next(input chirp_state_e wr_state);
    case (wr_state)
      ST_WR_OTG:     return ST_WR_FUN_RST;
      ST_WR_FUN_RST: return ST_DET_K;
      ST_WR_FUN_HS:  return ST_WAIT_RST_END;
      ST_WR_FUN_FS:  return ST_DONE_FS;
      default:       return ST_IDLE;
    endcase
  endfunction

  function automatic logic is_parked(input chirp_state_e s);
    return (s == ST_IDLE) || (s == ST_DONE_HS) || (s == ST_DONE_FS) || (s == ST_FAIL);
  endfunction

endpackage

// File: rtl/usb_linestate_filter.sv
// Contiguous-linestate run counter. With match_en_i low it is a plain
// saturating cycle counter; clr_i always wins.
module usb_linestate_filter #(
  parameter int unsigned W = 16
) (
  input  logic         CLK_60M,
  input  logic         NRST_A_USB,
  input  logic         clr_i,
  input  logic         match_en_i,
  input  logic [1:0]   linestate_i,
  input  logic [1:0]   target_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || (match_en_i && (linestate_i != target_i))) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/usb_host_chirp_ctrl.sv
// Host-side USB 2.0 HS detection: bus reset, device chirp K detection,
// host K/J chirping and final HS/FS PHY setup. Optional: HOST_CHIRP_PAIR_CNT_EN.
module usb_host_chirp_ctrl
  import usb_ulpi_pkg::*;
#(
  parameter int unsigned T_RESET   = 600000,
  parameter int unsigned T_DET_K   = 150,
  parameter int unsigned T_KJ      = 2700,
  parameter int unsigned T_STOP    = 12000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       CLK_60M,
  input  logic       NRST_A_USB,
  input  logic       START,
  input  logic       READY,
  input  logic [7:0] RXCMD,
  output logic       REG_EN,
  output logic       REG_RW,
  output logic [5:0] REG_ADDR,
  output logic [7:0] REG_DATA,
  input  logic       REG_DONE,
  input  logic       REG_FAIL,
  output logic [7:0] TX_DATA,
  output logic       TX_START_END,
  input  logic       TX_STRB,
  input  logic       TX_FAIL,
  output logic       HS_MODE,
  output logic       FS_MODE,
  output logic       BUSY,
  output logic       ERR,
  output logic [7:0] STATE
`ifdef HOST_CHIRP_PAIR_CNT_EN
  ,
  output logic [7:0] CHIRP_PAIRS
`endif
);

  localparam int unsigned STOP_I = T_RESET - T_STOP;
  localparam int unsigned KJ_I   = T_KJ - 1;
  localparam logic [19:0] RST_END = T_RESET[19:0];
  localparam logic [19:0] STOP_AT = STOP_I[19:0];
  localparam logic [15:0] DETK_LEN = T_DET_K[15:0];
  localparam logic [15:0] KJ_LAST  = KJ_I[15:0];

  chirp_state_e state_q, state_d;
  chirp_state_e wr_ret_q, wr_ret_d;
  logic [3:0]   retry_q, retry_d;
  logic [19:0]  rst_tmr_q, rst_tmr_d;
  logic [15:0]  phase_cnt;
  logic         start_seq;
  logic [1:0]   linestate;
  logic         unused_inputs;

`ifdef HOST_CHIRP_PAIR_CNT_EN
  logic [7:0] pairs_q, pairs_d;
  logic [7:0] pairs_inc;
  assign pairs_inc = (pairs_q == 8'hFF) ? pairs_q : pairs_q + 8'd1;
  assign CHIRP_PAIRS = pairs_q;
`endif

  assign linestate     = RXCMD[1:0];
  // Chirp timing is cycle-based; the byte strobe and RXCMD flag bits are not needed.
  assign unused_inputs = ^{RXCMD[7:2], TX_STRB};

  // phase_cnt doubles as the K-run counter while in DET_K.
  usb_linestate_filter #(.W(16)) u_ls_filter (
    .CLK_60M     (CLK_60M),
    .NRST_A_USB  (NRST_A_USB),
    .clr_i       (state_d != state_q),
    .match_en_i  (state_q == ST_DET_K),
    .linestate_i (linestate),
    .target_i    (LS_K),
    .cnt_o       (phase_cnt)
  );

  always_comb begin
    state_d      = state_q;
    wr_ret_d     = wr_ret_q;
    retry_d      = retry_q;
    rst_tmr_d    = (rst_tmr_q == '1) ? rst_tmr_q : rst_tmr_q + 20'd1;
    start_seq    = 1'b0;
    REG_EN       = 1'b0;
    REG_RW       = 1'b0;
    REG_ADDR     = 6'h00;
    REG_DATA     = 8'h00;
    TX_DATA      = TX_K_BYTE;
    TX_START_END = 1'b0;
`ifdef HOST_CHIRP_PAIR_CNT_EN
    pairs_d      = pairs_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (START && READY) begin
          start_seq = 1'b1;
          state_d   = ST_WR_OTG;
        end
      end
      ST_DONE_HS, ST_DONE_FS, ST_FAIL: begin
        if (START) begin
          start_seq = 1'b1;
          state_d   = ST_WR_OTG;
        end
      end
      ST_WR_OTG: begin
        REG_EN   = 1'b1;
        REG_RW   = 1'b1;
        REG_ADDR = ULPI_OTG_CTRL;
        REG_DATA = OTG_PULLDOWNS;
        wr_ret_d = ST_WR_OTG;
        state_d  = ST_WAIT_WR;
      end
      ST_WR_FUN_RST: begin
        REG_EN   = 1'b1;
        REG_RW   = 1'b1;
        REG_ADDR = ULPI_FUN_CTRL;
        REG_DATA = FUN_CHIRP;
        wr_ret_d = ST_WR_FUN_RST;
        state_d  = ST_WAIT_WR;
      end
      ST_WR_FUN_HS: begin
        REG_EN   = 1'b1;
        REG_RW   = 1'b1;
        REG_ADDR = ULPI_FUN_CTRL;
        REG_DATA = FUN_HS;
        wr_ret_d = ST_WR_FUN_HS;
        state_d  = ST_WAIT_WR;
      end
      ST_WR_FUN_FS: begin
        REG_EN   = 1'b1;
        REG_RW   = 1'b1;
        REG_ADDR = ULPI_FUN_CTRL;
        REG_DATA = FUN_FS;
        wr_ret_d = ST_WR_FUN_FS;
        state_d  = ST_WAIT_WR;
      end
      ST_WAIT_WR: begin
        if (REG_DONE) begin
          retry_d = '0;
          state_d = wr_next(wr_ret_q);
        end else if (REG_FAIL) begin
          if (({28'd0, retry_q} + 32'd1) > MAX_RETRY) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = wr_ret_q;
          end
        end
      end
      ST_DET_K: begin
        if (rst_tmr_q >= RST_END) begin
          state_d = ST_WR_FUN_FS;
        end else if (phase_cnt >= DETK_LEN) begin
          state_d = ST_WAIT_K_END;
        end
      end
      ST_WAIT_K_END: begin
        if (rst_tmr_q >= STOP_AT) begin
          state_d = ST_WR_FUN_FS;
        end else if (linestate != LS_K) begin
          state_d = ST_TX_OPEN;
        end
      end
      ST_TX_OPEN: begin
        TX_START_END = 1'b1;
        state_d      = TX_FAIL ? ST_FAIL : ST_CHIRP_K;
      end
      ST_CHIRP_K: begin
        if (TX_FAIL) begin
          state_d = ST_FAIL;
        end else if (phase_cnt >= KJ_LAST) begin
          state_d = ST_CHIRP_J;
        end
      end
      ST_CHIRP_J: begin
        TX_DATA = TX_J_BYTE;
        if (TX_FAIL) begin
          state_d = ST_FAIL;
        end else if (phase_cnt >= KJ_LAST) begin
`ifdef HOST_CHIRP_PAIR_CNT_EN
          pairs_d = pairs_inc;
`endif
          // Stop decision only at the end of a J so the chirp train ends on J.
          if (rst_tmr_q >= STOP_AT) begin
`ifdef HOST_CHIRP_PAIR_CNT_EN
            state_d = (pairs_inc < 8'd3) ? ST_FAIL : ST_TX_CLOSE;
`else
            state_d = ST_TX_CLOSE;
`endif
          end else begin
            state_d = ST_CHIRP_K;
          end
        end
      end
      ST_TX_CLOSE: begin
        TX_START_END = 1'b1;
        state_d      = ST_WR_FUN_HS;
      end
      ST_WAIT_RST_END: begin
        if (rst_tmr_q >= RST_END) begin
          state_d = ST_DONE_HS;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_seq) begin
      retry_d = '0;
`ifdef HOST_CHIRP_PAIR_CNT_EN
      pairs_d = 8'd0;
`endif
    end
    if ((state_d == ST_DET_K) && (state_q != ST_DET_K)) begin
      rst_tmr_d = '0;
    end
  end

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      state_q   <= ST_IDLE;
      wr_ret_q  <= ST_IDLE;
      retry_q   <= '0;
      rst_tmr_q <= '0;
`ifdef HOST_CHIRP_PAIR_CNT_EN
      pairs_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ret_q  <= wr_ret_d;
      retry_q   <= retry_d;
      rst_tmr_q <= rst_tmr_d;
`ifdef HOST_CHIRP_PAIR_CNT_EN
      pairs_q   <= pairs_d;
`endif
    end
  end

  assign HS_MODE = (state_q == ST_DONE_HS);
  assign FS_MODE = (state_q == ST_DONE_FS);
  assign ERR     = (state_q == ST_FAIL);
  assign BUSY    = !is_parked(state_q);
  assign STATE   = state_q;

endmodule

// File: tb/tb_usb_host_chirp_ctrl.sv
// Directed bench for usb_host_chirp_ctrl with shortened timing parameters
// (T_RESET=3000, T_DET_K=150, T_KJ=100, T_STOP=500, MAX_RETRY=3).
module tb_usb_host_chirp_ctrl;
  import usb_ulpi_pkg::*;

  logic       CLK_60M = 1'b0;
  logic       NRST_A_USB = 1'b0;
  logic       START = 1'b0;
  logic       READY = 1'b0;
  logic [7:0] RXCMD = 8'h00;
  logic       REG_DONE = 1'b0;
  logic       REG_FAIL = 1'b0;
  logic       TX_STRB = 1'b1;
  logic       TX_FAIL = 1'b0;
  logic       REG_EN, REG_RW, TX_START_END, HS_MODE, FS_MODE, BUSY, ERR;
  logic [5:0] REG_ADDR;
  logic [7:0] REG_DATA, TX_DATA, STATE;

  int n_asserts = 0;
  int n_fail = 0;
  int tx_pulses = 0;
  int n_fun_rst_wr = 0;
  int fail_left = 0;
  logic [5:0] last_addr = 6'h00;
  logic [7:0] last_data = 8'h00;
  int first_seen [256];
  int k_cycles, j_cycles, tx_bad;

  usb_host_chirp_ctrl #(
    .T_RESET(3000), .T_DET_K(150), .T_KJ(100), .T_STOP(500), .MAX_RETRY(3)
  ) dut (
    .CLK_60M(CLK_60M), .NRST_A_USB(NRST_A_USB), .START(START), .READY(READY),
    .RXCMD(RXCMD), .REG_EN(REG_EN), .REG_RW(REG_RW), .REG_ADDR(REG_ADDR),
    .REG_DATA(REG_DATA), .REG_DONE(REG_DONE), .REG_FAIL(REG_FAIL),
    .TX_DATA(TX_DATA), .TX_START_END(TX_START_END), .TX_STRB(TX_STRB),
    .TX_FAIL(TX_FAIL), .HS_MODE(HS_MODE), .FS_MODE(FS_MODE), .BUSY(BUSY),
    .ERR(ERR), .STATE(STATE)
  );

  always #5 CLK_60M = ~CLK_60M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_state(input chirp_state_e s, input int budget, input string tag);
    int n = 0;
    while (STATE !== s && n < budget) begin
      @(negedge CLK_60M);
      n++;
    end
    chk(tag, {24'd0, STATE}, {24'd0, s});
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(negedge CLK_60M);
    START = 1'b0;
  endtask

  task automatic pulse_reset();
    NRST_A_USB = 1'b0;
    @(negedge CLK_60M);
    NRST_A_USB = 1'b1;
    @(negedge CLK_60M);
  endtask

  // Runs n cycles from DET_K entry (d=0) driving the device linestate and
  // recording the first cycle each state code is seen.
  task automatic trace(input int n, input int k_end, input int glitch_at, input int start_at);
    for (int i = 0; i < 256; i++) first_seen[i] = -1;
    k_cycles = 0;
    j_cycles = 0;
    tx_bad = 0;
    for (int d = 0; d < n; d++) begin
      if (first_seen[STATE] == -1) first_seen[STATE] = d;
      if (STATE == ST_CHIRP_K) begin
        k_cycles++;
        if (TX_DATA !== 8'h00) tx_bad++;
      end
      if (STATE == ST_CHIRP_J) begin
        j_cycles++;
        if (TX_DATA !== 8'hFF) tx_bad++;
      end
      RXCMD = (d < k_end && d != glitch_at) ? 8'h02 : 8'h00;
      START = (d == start_at);
      @(negedge CLK_60M);
    end
    RXCMD = 8'h00;
    START = 1'b0;
  endtask

  // PHY register port: answers each request one cycle into WAIT_WR.
  initial begin
    logic pending = 1'b0;
    logic [5:0] a;
    logic [7:0] dv;
    forever begin
      @(negedge CLK_60M);
      REG_DONE = 1'b0;
      REG_FAIL = 1'b0;
      if (pending) begin
        pending = 1'b0;
        if (fail_left > 0 && a == 6'h04 && dv == 8'h50) begin
          fail_left--;
          REG_FAIL = 1'b1;
          $display("reg write addr=0x%02h data=0x%02h resp=abort", a, dv);
        end else begin
          REG_DONE = 1'b1;
          $display("reg write addr=0x%02h data=0x%02h resp=done", a, dv);
        end
      end
      if (REG_EN === 1'b1) begin
        a = REG_ADDR;
        dv = REG_DATA;
        last_addr = a;
        last_data = dv;
        if (a == 6'h04 && dv == 8'h50) n_fun_rst_wr++;
        pending = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK_60M);
      if (TX_START_END === 1'b1) begin
        tx_pulses++;
        $display("tx start/end pulse state=0x%02h data=0x%02h", STATE, TX_DATA);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, state=0x%02h", STATE);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge CLK_60M);
    chk("rst_state", {24'd0, STATE}, {24'd0, ST_IDLE});
    chk("rst_flags", {25'd0, REG_EN, REG_RW, TX_START_END, HS_MODE, FS_MODE, BUSY, ERR}, 32'd0);
    chk("rst_buses", {10'd0, REG_ADDR, REG_DATA, TX_DATA}, 32'd0);
    NRST_A_USB = 1'b1;
    @(negedge CLK_60M);

    pulse_start();
    repeat (2) @(negedge CLK_60M);
    chk("start_not_ready", {24'd0, STATE}, {24'd0, ST_IDLE});

    // Normal HS handshake
    READY = 1'b1;
    pulse_start();
    chk("wr_otg_state", {24'd0, STATE}, {24'd0, ST_WR_OTG});
    chk("wr_otg_bus", {14'd0, REG_EN, REG_RW, REG_ADDR, REG_DATA, BUSY, 1'b0},
        {14'd0, 1'b1, 1'b1, 6'h0A, 8'h06, 1'b1, 1'b0});
    @(negedge CLK_60M);
    chk("wait_wr_bus_idle", {17'd0, REG_EN, REG_RW, REG_ADDR, REG_DATA}, 32'd0);
    wait_state(ST_DET_K, 50, "hs_det_k_entry");
    chk("hs_fun_rst_writes", n_fun_rst_wr, 1);
    tx_pulses = 0;
    trace(3010, 300, -1, 10);
    chk("hs_busy_start_ignored", first_seen[ST_WR_OTG], -1);
    chk("hs_k_accept", first_seen[ST_WAIT_K_END], 151);
    chk("hs_tx_open", first_seen[ST_TX_OPEN], 301);
    chk("hs_tx_close", first_seen[ST_TX_CLOSE], 2502);
    chk("hs_wr_fun_hs", first_seen[ST_WR_FUN_HS], 2503);
    chk("hs_done_at_reset_end", first_seen[ST_DONE_HS], 3001);
    chk("hs_no_fs", first_seen[ST_WR_FUN_FS], -1);
    chk("hs_k_cycles", k_cycles, 1100);
    chk("hs_j_cycles", j_cycles, 1100);
    chk("hs_chirp_bytes", tx_bad, 0);
    chk("hs_tx_pulses", tx_pulses, 2);
    chk("hs_last_write", {18'd0, last_addr, last_data}, {18'd0, 6'h04, 8'h40});
    chk("hs_flags", {28'd0, HS_MODE, FS_MODE, BUSY, ERR}, {28'd0, 4'b1000});

    // Restart from DONE_HS, glitchy device K, then async reset mid-CHIRP_K
    pulse_start();
    chk("restart_state", {24'd0, STATE}, {24'd0, ST_WR_OTG});
    chk("restart_hs_clear", {31'd0, HS_MODE}, 32'd0);
    wait_state(ST_DET_K, 50, "gl_det_k_entry");
    tx_pulses = 0;
    trace(450, 400, 149, -1);
    chk("gl_k_accept", first_seen[ST_WAIT_K_END], 301);
    chk("gl_tx_open", first_seen[ST_TX_OPEN], 401);
    chk("gl_in_chirp_k", {24'd0, STATE}, {24'd0, ST_CHIRP_K});
    #2;
    NRST_A_USB = 1'b0;
    #1;
    chk("arst_state", {24'd0, STATE}, {24'd0, ST_IDLE});
    chk("arst_flags", {25'd0, REG_EN, REG_RW, TX_START_END, HS_MODE, FS_MODE, BUSY, ERR}, 32'd0);
    chk("arst_buses", {10'd0, REG_ADDR, REG_DATA, TX_DATA}, 32'd0);
    @(negedge CLK_60M);
    NRST_A_USB = 1'b1;
    repeat (50) @(negedge CLK_60M);
    chk("arst_no_tx", tx_pulses, 1);
    chk("arst_idle", {24'd0, STATE}, {24'd0, ST_IDLE});

    // Two register failures then success
    fail_left = 2;
    n_fun_rst_wr = 0;
    pulse_start();
    wait_state(ST_DET_K, 100, "retry_reaches_det_k");
    chk("retry_writes", n_fun_rst_wr, 3);
    chk("retry_no_err", {31'd0, ERR}, 32'd0);
    pulse_reset();

    // Four consecutive failures
    fail_left = 4;
    n_fun_rst_wr = 0;
    pulse_start();
    wait_state(ST_FAIL, 100, "retry_exhausted");
    chk("retry4_writes", n_fun_rst_wr, 4);
    chk("retry4_flags", {30'd0, BUSY, ERR}, {30'd0, 2'b01});

    // Restart from FAIL, abort mid-CHIRP_J with TX_FAIL
    fail_left = 0;
    pulse_start();
    chk("fail_restart_state", {24'd0, STATE}, {24'd0, ST_WR_OTG});
    chk("fail_restart_err", {31'd0, ERR}, 32'd0);
    wait_state(ST_DET_K, 50, "txf_det_k_entry");
    trace(460, 300, -1, -1);
    chk("txf_in_chirp_j", {24'd0, STATE}, {24'd0, ST_CHIRP_J});
    TX_FAIL = 1'b1;
    @(negedge CLK_60M);
    TX_FAIL = 1'b0;
    chk("txf_state", {24'd0, STATE}, {24'd0, ST_FAIL});
    chk("txf_flags", {29'd0, HS_MODE, BUSY, ERR}, {29'd0, 3'b001});
    pulse_start();
    chk("txf_restart", {24'd0, STATE, 7'd0, ERR}, {24'd0, ST_WR_OTG, 8'd0});

    // No device chirp: FS fallback
    wait_state(ST_DET_K, 50, "fs_det_k_entry");
    tx_pulses = 0;
    trace(3010, 0, -1, -1);
    chk("fs_wr_fun_fs", first_seen[ST_WR_FUN_FS], 3001);
    chk("fs_done", first_seen[ST_DONE_FS], 3003);
    chk("fs_no_tx_open", first_seen[ST_TX_OPEN], -1);
    chk("fs_tx_pulses", tx_pulses, 0);
    chk("fs_last_write", {18'd0, last_addr, last_data}, {18'd0, 6'h04, 8'h45});
    chk("fs_flags", {28'd0, HS_MODE, FS_MODE, BUSY, ERR}, {28'd0, 4'b0100});

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
